fdiv_seq: RTL and testbench
===========================

FDIV_SEQ -- requirements
Module: fdiv_seq

Interface
REQ-001 SHALL provide clk  input  1  rising-edge clock for all state.
REQ-002 SHALL provide rst  input  1  reset (synchronous, active-high).
REQ-003 SHALL provide start  input  1  request; sampled only in IDLE.
REQ-004 SHALL provide A_sign/A_exp/A_frac  input  1/8/23  dividend fields (IEEE-754 single, unpacked).
REQ-005 SHALL provide B_sign/B_exp/B_frac  input  1/8/23  divisor fields.
REQ-006 SHALL provide busy  output  1  high whenever state != IDLE.
REQ-007 SHALL provide done  output  1  one-cycle result-valid pulse.
REQ-008 SHALL provide sign/exp/frac  output  1/8/24  result; frac = 24 bits directly below the hidden one, MSB weight 2^-1.
REQ-009 SHALL provide error  output  1  invalid operation (NaN result).
REQ-010 SHALL provide overflow  output  1  exponent overflow, result forced to inf.

Function
REQ-011 SHALL run FSM IDLE -> CALC -> NORM -> DONE -> IDLE; start in IDLE captures all operand inputs into registers on that edge.
REQ-012 SHALL ignore start in CALC, NORM and DONE; operand inputs are don't-care after capture.
REQ-013 SHALL classify operands: exp=0 is zero (denormals flushed), exp=255 & frac=0 is inf, exp=255 & frac!=0 is NaN.
REQ-014 SHALL resolve in priority order: NaN operand, inf/inf, 0/0 -> exp=8'hff, frac=24'h800000, error=1; else inf/x or x/0 -> exp=8'hff, frac=0, error=0; else 0/x or x/inf -> exp=0, frac=0, error=0.
REQ-015 SHALL take special cases IDLE -> NORM -> DONE, skipping CALC (done visible 2 edges after start).
REQ-016 SHALL in CALC perform radix-2 restoring division, one quotient bit per cycle, on Ma={1,A_frac}, Mb={1,B_frac}, producing Q=floor(Ma*2^25/Mb), 26 bits, 26 cycles.
REQ-017 SHALL normalize in NORM: Q[25]=1 -> frac=Q[24:1], e=A_exp-B_exp+127; else frac=Q[23:0], e=A_exp-B_exp+126; e in 10-bit signed.
REQ-018 SHALL on e>=255 output exp=8'hff, frac=0, overflow=1; on e<=0 output exp=0, frac=0, overflow=0.
REQ-019 SHALL set sign=A_sign^B_sign for every result, including special cases.
REQ-020 SHALL update sign/exp/frac/error/overflow only on entry to DONE and hold them until the next DONE.
REQ-021 SHALL assert done only in DONE, exactly one cycle; normal latency = 28 edges from start sample to done visible.

Reset
REQ-022 SHALL on rst=1 at a clock edge force IDLE, busy=0, done=0, sign=0, exp=0, frac=0, error=0, overflow=0, clear quotient/remainder registers.
REQ-023 SHALL let rst override start and any in-flight operation; aborted operations never produce done.

Configuration
REQ-024 SHALL support macro FDIV_ROUND_EN.
REQ-025 With FDIV_ROUND_EN defined, SHALL compute 27 quotient bits (CALC = 27 cycles, latency 29) and round frac to nearest-even using the extra bit plus nonzero-remainder sticky; a frac carry-out SHALL set frac=0 and increment e before REQ-018 checks.
REQ-026 Without FDIV_ROUND_EN, SHALL truncate per REQ-016/017 with no rounding logic.

Verification
REQ-027 6.0/2.0 (A exp=129 frac=0x400000, B exp=128 frac=0) -> exp=128, frac=0x800000, sign=0, error=0, done at edge 28.
REQ-028 1.0/-3.0 (A exp=127 frac=0; B sign=1 exp=128 frac=0x400000) -> sign=1, exp=125, frac=0x555555 (both configs).
REQ-029 A exp=254 frac=0 / B exp=1 frac=0 -> overflow=1, exp=8'hff, frac=0; swapped -> exp=0, frac=0, overflow=0.
REQ-030 A exp=255 frac=1 / any -> exp=8'hff, frac=0x800000, error=1, done 2 edges after start; 1.0/0.0 -> exp=8'hff, frac=0, error=0.
REQ-031 rst pulsed in CALC cycle 10 -> next edge IDLE, all outputs 0, no done; new start then completes normally.
REQ-032 start held high continuously -> back-to-back operations, each done one cycle, start ignored while busy.

Source files
------------

// File: rtl/fdiv_seq.sv
// fdiv_seq -- sequential IEEE-754 single-precision divider (radix-2 restoring).
//
// Ports:
//   clk                      rising-edge clock for all state
//   rst                      synchronous active-high reset
//   start                    request; sampled only while idle
//   A_sign/A_exp/A_frac      dividend fields (1/8/23)
//   B_sign/B_exp/B_frac      divisor fields (1/8/23)
//   busy                     high whenever the FSM is not idle
//   done                     one-cycle result-valid pulse
//   sign/exp/frac            result; frac is the 24 bits directly below the
//                            hidden one (MSB weight 2^-1)
//   error                    invalid operation (NaN result)
//   overflow                 exponent overflow, result forced to infinity
//
// Configuration macro:
//   FDIV_ROUND_EN  when defined, one extra quotient bit is produced and the
//                  fraction is rounded to nearest-even (guard + sticky).
//                  When undefined, the quotient is truncated.
//
// FSM: IDLE -> CALC -> NORM -> DONE -> IDLE. Special operands (zero, inf,
// NaN) skip CALC and go straight to NORM.

module fdiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        A_sign,
  input  logic [7:0]  A_exp,
  input  logic [22:0] A_frac,
  input  logic        B_sign,
  input  logic [7:0]  B_exp,
  input  logic [22:0] B_frac,
  output logic        busy,
  output logic        done,
  output logic        sign,
  output logic [7:0]  exp,
  output logic [23:0] frac,
  output logic        error,
  output logic        overflow
);

`ifdef FDIV_ROUND_EN
  localparam int QW = 27;
`else
  localparam int QW = 26;
`endif
  localparam logic [4:0] CNT_INIT = 5'(QW - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_NORM, ST_DONE} state_t;
  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

  state_t          state_reg;
  special_t        special_reg;
  special_t        special_in;
  logic [7:0]      a_exp_reg;
  logic [7:0]      b_exp_reg;
  logic [23:0]     mb_reg;
  logic [24:0]     rem_reg;
  logic [QW-1:0]   quo_reg;
  logic [4:0]      cnt_reg;
  logic            sign_res_reg;
  logic            done_reg;
  logic            sign_reg;
  logic [7:0]      exp_reg;
  logic [23:0]     frac_reg;
  logic            error_reg;
  logic            overflow_reg;

  // ---------------------------------------------------------------------
  // Operand classification (index 0 = dividend, 1 = divisor).
  // Denormals are flushed: any exponent of zero is treated as zero.
  // ---------------------------------------------------------------------
  logic [1:0][7:0]  op_exp;
  logic [1:0][22:0] op_frac;
  logic [1:0]       op_zero;
  logic [1:0]       op_inf;
  logic [1:0]       op_nan;

  assign op_exp  = {B_exp, A_exp};
  assign op_frac = {B_frac, A_frac};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_class
      assign op_zero[gi] = (op_exp[gi] == 8'd0);
      assign op_inf[gi]  = (op_exp[gi] == 8'hff) && (op_frac[gi] == 23'd0);
      assign op_nan[gi]  = (op_exp[gi] == 8'hff) && (op_frac[gi] != 23'd0);
    end
  endgenerate

  // Priority: invalid first, then infinite result, then zero result.
  always_comb begin
    special_in = SP_NONE;
    if ((|op_nan) || (&op_inf) || (&op_zero))
      special_in = SP_NAN;
    else if (op_inf[0] || op_zero[1])
      special_in = SP_INF;
    else if (op_zero[0] || op_inf[1])
      special_in = SP_ZERO;
  end

  // ---------------------------------------------------------------------
  // Restoring division step. The partial remainder stays below 2*Mb, so
  // 25 bits are enough; the shifted-out top bit is always zero.
  // ---------------------------------------------------------------------
  logic [25:0] trial;
  logic        q_bit;
  logic [24:0] rem_sel;

  assign trial   = {1'b0, rem_reg} - {2'b00, mb_reg};
  assign q_bit   = ~trial[25];
  assign rem_sel = q_bit ? trial[24:0] : rem_reg;

  // ---------------------------------------------------------------------
  // Normalisation (and optional rounding) of the finished quotient.
  // ---------------------------------------------------------------------
  logic               q_top;
  logic signed [9:0]  e_base;
  logic signed [9:0]  e_norm;
  logic signed [9:0]  e_fin;
  logic [23:0]        frac_fin;

  assign q_top = quo_reg[QW-1];

`ifdef FDIV_ROUND_EN
  logic [23:0] frac_pre;
  logic        guard_bit;
  logic        sticky_bit;
  logic        round_up;
  logic [24:0] frac_sum;

  always_comb begin
    e_base     = $signed({2'b00, a_exp_reg}) - $signed({2'b00, b_exp_reg}) + 10'sd126;
    e_norm     = e_base + $signed({9'd0, q_top});
    frac_pre   = q_top ? quo_reg[25:2] : quo_reg[24:1];
    guard_bit  = q_top ? quo_reg[1] : quo_reg[0];
    sticky_bit = (q_top & quo_reg[0]) | (rem_reg != 25'd0);
    round_up   = guard_bit & (sticky_bit | frac_pre[0]);
    frac_sum   = {1'b0, frac_pre} + {24'd0, round_up};
    // A carry-out means the mantissa rounded up to 2.0: fraction wraps to
    // zero and the exponent moves up one before range checking.
    frac_fin   = frac_sum[23:0];
    e_fin      = e_norm + $signed({9'd0, frac_sum[24]});
  end
`else
  always_comb begin
    e_base   = $signed({2'b00, a_exp_reg}) - $signed({2'b00, b_exp_reg}) + 10'sd126;
    e_norm   = e_base + $signed({9'd0, q_top});
    frac_fin = q_top ? quo_reg[24:1] : quo_reg[23:0];
    e_fin    = e_norm;
  end
`endif

  // ---------------------------------------------------------------------
  // Control FSM and result registers.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      special_reg  <= SP_NONE;
      a_exp_reg    <= '0;
      b_exp_reg    <= '0;
      mb_reg       <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      cnt_reg      <= '0;
      sign_res_reg <= 1'b0;
      done_reg     <= 1'b0;
      sign_reg     <= 1'b0;
      exp_reg      <= '0;
      frac_reg     <= '0;
      error_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            a_exp_reg    <= A_exp;
            b_exp_reg    <= B_exp;
            mb_reg       <= {1'b1, B_frac};
            rem_reg      <= {2'b01, A_frac};
            quo_reg      <= '0;
            cnt_reg      <= CNT_INIT;
            sign_res_reg <= A_sign ^ B_sign;
            special_reg  <= special_in;
            state_reg    <= (special_in == SP_NONE) ? ST_CALC : ST_NORM;
          end
        end
        ST_CALC: begin
          quo_reg <= {quo_reg[QW-2:0], q_bit};
          rem_reg <= rem_sel << 1;
          if (cnt_reg == 5'd0)
            state_reg <= ST_NORM;
          else
            cnt_reg <= cnt_reg - 5'd1;
        end
        ST_NORM: begin
          sign_reg     <= sign_res_reg;
          error_reg    <= 1'b0;
          overflow_reg <= 1'b0;
          case (special_reg)
            SP_NAN: begin
              exp_reg   <= 8'hff;
              frac_reg  <= 24'h800000;
              error_reg <= 1'b1;
            end
            SP_INF: begin
              exp_reg  <= 8'hff;
              frac_reg <= '0;
            end
            SP_ZERO: begin
              exp_reg  <= '0;
              frac_reg <= '0;
            end
            default: begin
              if (e_fin >= 10'sd255) begin
                exp_reg      <= 8'hff;
                frac_reg     <= '0;
                overflow_reg <= 1'b1;
              end else if (e_fin <= 10'sd0) begin
                exp_reg  <= '0;
                frac_reg <= '0;
              end else begin
                exp_reg  <= e_fin[7:0];
                frac_reg <= frac_fin;
              end
            end
          endcase
          done_reg  <= 1'b1;
          state_reg <= ST_DONE;
        end
        ST_DONE: begin
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;
  assign sign     = sign_reg;
  assign exp      = exp_reg;
  assign frac     = frac_reg;
  assign error    = error_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_fdiv_seq.sv
// Testbench for fdiv_seq: directed vectors with hand-computed results.
// A driver pushes the expected result and the edge at which done must be
// visible into a scoreboard queue; a monitor pops and compares on done.
module tb_fdiv_seq;

`ifdef FDIV_ROUND_EN
  localparam int          LAT_N  = 29;
  localparam logic [23:0] F_5_6  = 24'haaaaab;
`else
  localparam int          LAT_N  = 28;
  localparam logic [23:0] F_5_6  = 24'haaaaaa;
`endif
  localparam int LAT_S = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        A_sign;
  logic [7:0]  A_exp;
  logic [22:0] A_frac;
  logic        B_sign;
  logic [7:0]  B_exp;
  logic [22:0] B_frac;
  logic        busy;
  logic        done;
  logic        sign;
  logic [7:0]  exp;
  logic [23:0] frac;
  logic        error;
  logic        overflow;

  always #5 clk = ~clk;

  fdiv_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A_sign   (A_sign),
    .A_exp    (A_exp),
    .A_frac   (A_frac),
    .B_sign   (B_sign),
    .B_exp    (B_exp),
    .B_frac   (B_frac),
    .busy     (busy),
    .done     (done),
    .sign     (sign),
    .exp      (exp),
    .frac     (frac),
    .error    (error),
    .overflow (overflow)
  );

  typedef struct {
    logic [34:0] res;
    int          edge_n;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   op_id  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [34:0] r(input logic s, input logic [7:0] e,
                                    input logic [23:0] f, input logic er,
                                    input logic ov);
    return {s, e, f, er, ov};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 at edge %0d, expected no pending result", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("op%0d_result", mon_e.id),
            64'({sign, exp, frac, error, overflow}), 64'(mon_e.res));
        chk($sformatf("op%0d_done_edge", mon_e.id), 64'(cyc), 64'(mon_e.edge_n));
        $display("op %0d: sign=%b exp=%h frac=%h error=%b overflow=%b at edge %0d",
                 mon_e.id, sign, exp, frac, error, overflow, cyc);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%b, expected 0", busy);
    end
  endtask

  // Called on a negedge; the following posedge samples start.
  task automatic issue(input logic as, input logic [7:0] ae, input logic [22:0] af,
                       input logic bs, input logic [7:0] be, input logic [22:0] bf,
                       input logic [34:0] res, input int lat, input bit push);
    exp_t e;
    wait_idle();
    A_sign = as; A_exp = ae; A_frac = af;
    B_sign = bs; B_exp = be; B_frac = bf;
    start  = 1'b1;
    if (push) begin
      e.res    = res;
      e.edge_n = cyc + lat;
      e.id     = op_id;
      sb.push_back(e);
    end
    op_id++;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   n;
    int   c0;
    rst = 1'b1; start = 1'b0;
    A_sign = 1'b0; A_exp = '0; A_frac = '0;
    B_sign = 1'b0; B_exp = '0; B_frac = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", 64'({busy, done, sign, exp, frac, error, overflow}), 64'd0);

    // Normal divisions and exponent boundaries.
    issue(0, 8'd129, 23'h400000, 0, 8'd128, 23'h000000, r(0, 8'd128, 24'h800000, 0, 0), LAT_N, 1); // 6/2
    issue(0, 8'd127, 23'h000000, 1, 8'd128, 23'h400000, r(1, 8'd125, 24'h555555, 0, 0), LAT_N, 1); // 1/-3
    issue(0, 8'd127, 23'h200000, 0, 8'd127, 23'h400000, r(0, 8'd126, F_5_6,      0, 0), LAT_N, 1); // 1.25/1.5
    issue(0, 8'd254, 23'h000000, 0, 8'd1,   23'h000000, r(0, 8'hff,  24'h000000, 0, 1), LAT_N, 1); // overflow
    issue(0, 8'd1,   23'h000000, 0, 8'd254, 23'h000000, r(0, 8'd0,   24'h000000, 0, 0), LAT_N, 1); // underflow
    issue(0, 8'd254, 23'h000000, 0, 8'd126, 23'h000000, r(0, 8'hff,  24'h000000, 0, 1), LAT_N, 1); // e=255
    issue(0, 8'd254, 23'h000000, 0, 8'd127, 23'h000000, r(0, 8'd254, 24'h000000, 0, 0), LAT_N, 1); // e=254
    issue(1, 8'd1,   23'h000000, 0, 8'd127, 23'h400000, r(1, 8'd0,   24'h000000, 0, 0), LAT_N, 1); // e=0

    // Special operands.
    issue(0, 8'd255, 23'h000001, 1, 8'd127, 23'h000000, r(1, 8'hff, 24'h800000, 1, 0), LAT_S, 1); // NaN/x
    issue(0, 8'd127, 23'h000000, 0, 8'd0,   23'h000000, r(0, 8'hff, 24'h000000, 0, 0), LAT_S, 1); // 1/0
    issue(0, 8'd0,   23'h000005, 0, 8'd0,   23'h000000, r(0, 8'hff, 24'h800000, 1, 0), LAT_S, 1); // 0/0
    issue(1, 8'd255, 23'h000000, 0, 8'd255, 23'h000000, r(1, 8'hff, 24'h800000, 1, 0), LAT_S, 1); // inf/inf
    issue(0, 8'd255, 23'h000000, 1, 8'd0,   23'h000000, r(1, 8'hff, 24'h000000, 0, 0), LAT_S, 1); // inf/0
    issue(0, 8'd0,   23'h000000, 0, 8'd255, 23'h000000, r(0, 8'd0,  24'h000000, 0, 0), LAT_S, 1); // 0/inf
    issue(0, 8'd128, 23'h400000, 1, 8'd255, 23'h000000, r(1, 8'd0,  24'h000000, 0, 0), LAT_S, 1); // 3/inf
    issue(0, 8'd255, 23'h000000, 0, 8'd255, 23'h000007, r(0, 8'hff, 24'h800000, 1, 0), LAT_S, 1); // inf/NaN

    // Abort a division in CALC cycle 10 with reset; it must never complete.
    issue(0, 8'd127, 23'h000000, 1, 8'd128, 23'h400000, '0, LAT_N, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", 64'({busy, done, sign, exp, frac, error, overflow}), 64'd0);
    repeat (40) @(negedge clk);
    chk("abort_stays_idle", 64'({busy, done}), 64'd0);

    // Recovery after abort.
    issue(0, 8'd129, 23'h400000, 0, 8'd128, 23'h000000, r(0, 8'd128, 24'h800000, 0, 0), LAT_N, 1);

    // start held high: three back-to-back operations.
    wait_idle();
    A_sign = 1'b0; A_exp = 8'd127; A_frac = 23'h000000;
    B_sign = 1'b1; B_exp = 8'd128; B_frac = 23'h400000;
    start = 1'b1;
    c0 = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      e.res    = r(1, 8'd125, 24'h555555, 0, 0);
      e.edge_n = c0 + LAT_N - 1 + k * (LAT_N + 1);
      e.id     = op_id;
      sb.push_back(e);
      op_id++;
    end
    repeat (2 * (LAT_N + 1) + 1) @(negedge clk);
    start = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
